// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared record layout, framing constants and capture states
package cpu_trace_pkg;

  localparam int REC_W   = 48;
  localparam int PC_OFF  = 40;
  localparam int OP_OFF  = 32;
  localparam int A_OFF   = 24;
  localparam int B_OFF   = 16;
  localparam int RES_OFF = 8;
  localparam int FLG_OFF = 0;

  localparam int FLAG_CARRY  = 0;
  localparam int FLAG_BORROW = 1;

  localparam int         FRAME_LEN      = 7;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_ACK,
    CAP_HOLD
  } cap_state_e;

  // Byte idx of the frame built around rec: header first, flags last.
  function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] rec,
                                            input logic [2:0]       idx,
                                            input logic [7:0]       header);
    logic [7:0] b;
    case (idx)
      3'd0:    b = header;
      3'd1:    b = rec[PC_OFF +: 8];
      3'd2:    b = rec[OP_OFF +: 8];
      3'd3:    b = rec[A_OFF +: 8];
      3'd4:    b = rec[B_OFF +: 8];
      3'd5:    b = rec[RES_OFF +: 8];
      default: b = rec[FLG_OFF +: 8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous record FIFO, combinational head read
module trace_fifo
  import cpu_trace_pkg::*;
#(
  parameter int WIDTH = REC_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - captures cpu result records and streams them as framed bytes
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter int         HOLDOFF = 5,
  parameter logic [7:0] HEADER  = DEFAULT_HEADER
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture_en,
  input  logic                   result_ready,
  input  logic [7:0]             pc_out,
  input  logic [7:0]             opcode,
  input  logic [7:0]             operand_A_out,
  input  logic [7:0]             operand_B_out,
  input  logic [7:0]             result_out_cpu,
  input  logic                   carry_out_cpu,
  input  logic                   borrow_out_cpu,
  output logic                   next_out,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [15:0]            record_count
);

  localparam int HW = $clog2(HOLDOFF + 2);

  cap_state_e       state_q;
  cap_state_e       state_d;
  logic [HW-1:0]    hold_cnt;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_head;
  logic [REC_W-1:0] rec_cur;
  logic [2:0]       byte_idx;

  always_comb begin
    rec_in                          = '0;
    rec_in[PC_OFF +: 8]             = pc_out;
    rec_in[OP_OFF +: 8]             = opcode;
    rec_in[A_OFF +: 8]              = operand_A_out;
    rec_in[B_OFF +: 8]              = operand_B_out;
    rec_in[RES_OFF +: 8]            = result_out_cpu;
    rec_in[FLG_OFF + FLAG_CARRY]    = carry_out_cpu;
    rec_in[FLG_OFF + FLAG_BORROW]   = borrow_out_cpu;
  end

  // Full is sampled before any same-cycle pop, so a freed slot is only usable next edge.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (capture_en && result_ready && !full) begin
          push    = 1'b1;
          state_d = CAP_ACK;
        end
      end
      CAP_ACK:  state_d = CAP_HOLD;
      CAP_HOLD: begin
        if (hold_cnt <= HW'(1)) state_d = CAP_IDLE;
      end
      default:  state_d = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CAP_IDLE;
      hold_cnt     <= '0;
      record_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CAP_ACK)
        hold_cnt <= HW'(HOLDOFF);
      else if (state_q == CAP_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - HW'(1);
      if (push) record_count <= record_count + 16'd1;
    end
  end

  assign next_out = (state_q == CAP_ACK);

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (rec_in),
    .dout  (rec_head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Popping only while tx_valid is low guarantees an idle cycle between frames.
  assign pop = !tx_valid && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      byte_idx <= '0;
      rec_cur  <= '0;
    end else if (pop) begin
      rec_cur  <= rec_head;
      byte_idx <= '0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (byte_idx == 3'(FRAME_LEN - 1)) begin
        tx_valid <= 1'b0;
        byte_idx <= '0;
      end else begin
        byte_idx <= byte_idx + 3'd1;
      end
    end
  end

  assign tx_data = tx_valid ? frame_byte(rec_cur, byte_idx, HEADER) : 8'h00;

endmodule
